csr_counter_bank: RTL and testbench

Parametrised bank of NUM_COUNTERS machine event counters, each WIDTH bits wide, with a shared count-inhibit CSR. It is accessed through the common CSR set/clear port convention. Each counter is exposed as a low-word CSR and a high-word CSR, increments on a per-channel event strobe, and flags wrap-around. It sits on the CSR bus beside the other machine-mode CSR blocks and serves mcycle/minstret/mhpmcounter-style registers.

---
 rtl/csr_counter_bank.sv | 139 +++++++++++++
 tb/tb_csr_counter_bank.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/csr_counter_bank.sv
// csr_counter_bank: WIDTH-bit event counters with lo/hi CSR halves and inhibit.
// Define CSR_COUNTER_HI_SNAPSHOT_EN for coherent lo-then-hi high-word reads.
module csr_counter_bank #(
  parameter int unsigned NUM_COUNTERS = 3,
  parameter int unsigned WIDTH        = 64,
  parameter logic [11:0] LO_BASE      = 12'hB00,
  parameter logic [11:0] HI_BASE      = 12'hB80,
  parameter logic [11:0] INHIBIT_ADDR = 12'h320
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic [11:0]             addr_i,
  input  logic [31:0]             set_i,
  input  logic [31:0]             clear_i,
  input  logic [NUM_COUNTERS-1:0] inc_i,
  output logic [31:0]             read_o,
  output logic                    ack_o,
  output logic [NUM_COUNTERS-1:0] ovf_o
);

  localparam int unsigned HW = WIDTH - 32;

  logic [WIDTH-1:0]        cnt     [NUM_COUNTERS];
  logic [WIDTH-1:0]        cnt_nxt [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] ovf;
  logic [NUM_COUNTERS-1:0] ovf_nxt;
  logic [NUM_COUNTERS-1:0] inhibit;
  logic [NUM_COUNTERS-1:0] inh_nxt;

  logic [NUM_COUNTERS-1:0] lo_hit;
  logic [NUM_COUNTERS-1:0] hi_hit;
  logic                    inh_hit;

  logic [31:0] hi_live [NUM_COUNTERS];
  logic [31:0] hi_rd   [NUM_COUNTERS];
  logic [31:0] lo_wr   [NUM_COUNTERS];
  logic [31:0] hi_wr   [NUM_COUNTERS];

`ifdef CSR_COUNTER_HI_SNAPSHOT_EN
  logic [HW-1:0] snap     [NUM_COUNTERS];
  logic [HW-1:0] snap_nxt [NUM_COUNTERS];
`endif

  always_comb begin
    lo_hit  = '0;
    hi_hit  = '0;
    inh_hit = en_i && (addr_i == INHIBIT_ADDR);
    for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
      lo_hit[i] = en_i && (addr_i == LO_BASE + 12'(i));
      hi_hit[i] = en_i && (addr_i == HI_BASE + 12'(i));
    end
  end

  assign ack_o = (|lo_hit) || (|hi_hit) || inh_hit;

  for (genvar g = 0; g < int'(NUM_COUNTERS); g++) begin : g_ch
    assign hi_live[g] = 32'(cnt[g][WIDTH-1:32]);
    assign lo_wr[g]   = (cnt[g][31:0] & ~clear_i) | set_i;
    // High-word writes always start from the live count.
    assign hi_wr[g]   = (hi_live[g] & ~clear_i) | set_i;
`ifdef CSR_COUNTER_HI_SNAPSHOT_EN
    assign hi_rd[g]   = 32'(snap[g]);
`else
    assign hi_rd[g]   = hi_live[g];
`endif
  end

  // At most one decode hits, so an OR-reduction acts as the read mux.
  always_comb begin
    read_o = '0;
    for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
      if (lo_hit[i]) read_o = read_o | cnt[i][31:0];
      if (hi_hit[i]) read_o = read_o | hi_rd[i];
    end
    if (inh_hit) read_o = read_o | 32'(inhibit);
  end

  always_comb begin
    inh_nxt = inhibit;
    if (inh_hit) begin
      inh_nxt = (inhibit & ~clear_i[NUM_COUNTERS-1:0])
              | set_i[NUM_COUNTERS-1:0];
    end
  end

  // A write to either half pre-empts that channel's increment.
  always_comb begin
    ovf_nxt = '0;
    for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
      cnt_nxt[i] = cnt[i];
`ifdef CSR_COUNTER_HI_SNAPSHOT_EN
      snap_nxt[i] = snap[i];
      if (lo_hit[i]) snap_nxt[i] = cnt[i][WIDTH-1:32];
`endif
      if (lo_hit[i]) begin
        cnt_nxt[i][31:0] = lo_wr[i];
      end else if (hi_hit[i]) begin
        cnt_nxt[i][WIDTH-1:32] = hi_wr[i][HW-1:0];
      end else if (inc_i[i] && !inhibit[i]) begin
        cnt_nxt[i] = cnt[i] + WIDTH'(1);
        ovf_nxt[i] = &cnt[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf     <= '0;
      inhibit <= '0;
      for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      ovf     <= ovf_nxt;
      inhibit <= inh_nxt;
      for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

`ifdef CSR_COUNTER_HI_SNAPSHOT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
        snap[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
        snap[i] <= snap_nxt[i];
      end
    end
  end
`endif

  assign ovf_o = ovf;

endmodule

// File: tb/tb_csr_counter_bank.sv
// tb_csr_counter_bank: directed plan plus random traffic vs a reference model.
// Honours CSR_COUNTER_HI_SNAPSHOT_EN the same way the design does.
module tb_csr_counter_bank;

  localparam int          N   = 3;
  localparam logic [11:0] LO  = 12'hB00;
  localparam logic [11:0] HI  = 12'hB80;
  localparam logic [11:0] INH = 12'h320;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [11:0]   addr;
  logic [31:0]   set_v;
  logic [31:0]   clr;
  logic [N-1:0]  inc;
  logic [31:0]   rd_data;
  logic          ack;
  logic [N-1:0]  ovf;

  csr_counter_bank dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en),
    .addr_i  (addr),
    .set_i   (set_v),
    .clear_i (clr),
    .inc_i   (inc),
    .read_o  (rd_data),
    .ack_o   (ack),
    .ovf_o   (ovf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  longint unsigned m_cnt  [N];
  logic [31:0]     m_snap [N];
  logic [N-1:0]    m_inh;
  logic [N-1:0]    m_ovf;

  logic [31:0]  last_rd;
  logic         last_ack;
  logic [N-1:0] last_ovf;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      m_cnt[i]  = 0;
      m_snap[i] = 0;
    end
    m_inh = '0;
    m_ovf = '0;
  endfunction

  function automatic logic exp_ack(input logic e, input logic [11:0] a);
    logic hit;
    hit = (a == INH);
    for (int i = 0; i < N; i++)
      if (a == 12'(LO + i) || a == 12'(HI + i)) hit = 1'b1;
    return e && hit;
  endfunction

  function automatic logic [31:0] exp_read(input logic e,
                                           input logic [11:0] a);
    logic [31:0] r;
    r = 0;
    if (e) begin
      for (int i = 0; i < N; i++) begin
        if (a == 12'(LO + i)) r = 32'(m_cnt[i]);
`ifdef CSR_COUNTER_HI_SNAPSHOT_EN
        if (a == 12'(HI + i)) r = m_snap[i];
`else
        if (a == 12'(HI + i)) r = 32'(m_cnt[i] >> 32);
`endif
      end
      if (a == INH) r = 32'(m_inh);
    end
    return r;
  endfunction

  // Model of one clock edge, written from the register semantics.
  function automatic void model_edge(input logic e, input logic [11:0] a,
                                     input logic [31:0] s,
                                     input logic [31:0] c,
                                     input logic [N-1:0] in);
    logic [31:0] oldv;
    m_ovf = '0;
    for (int i = 0; i < N; i++) begin
      if (e && a == 12'(LO + i)) begin
        m_snap[i] = 32'(m_cnt[i] >> 32);
        oldv      = 32'(m_cnt[i]);
        m_cnt[i]  = (m_cnt[i] & 64'hFFFF_FFFF_0000_0000)
                  | 64'((oldv & ~c) | s);
      end else if (e && a == 12'(HI + i)) begin
        oldv     = 32'(m_cnt[i] >> 32);
        m_cnt[i] = (m_cnt[i] & 64'h0000_0000_FFFF_FFFF)
                 | (64'((oldv & ~c) | s) << 32);
      end else if (in[i] && !m_inh[i]) begin
        m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] == 0) m_ovf[i] = 1'b1;
      end
    end
    if (e && a == INH) m_inh = (m_inh & ~c[N-1:0]) | s[N-1:0];
  endfunction

  task automatic cycle(input logic e, input logic [11:0] a,
                       input logic [31:0] s, input logic [31:0] c,
                       input logic [N-1:0] in);
    en = e; addr = a; set_v = s; clr = c; inc = in;
    #1;
    last_rd  = rd_data;
    last_ack = ack;
    last_ovf = ovf;
    chk("ack", 32'(ack), 32'(exp_ack(e, a)));
    chk("read", rd_data, exp_read(e, a));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    @(posedge clk);
    model_edge(e, a, s, c, in);
    @(negedge clk);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e,
                    input string tag);
    cycle(1'b1, a, 32'h0, 32'h0, '0);
    chk(tag, last_rd, e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b1; addr = LO; set_v = $urandom; clr = $urandom;
    inc = '1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    model_clear();
    rst = 1'b0;
  endtask

  function automatic logic [11:0] rand_addr();
    int k;
    k = int'($urandom_range(0, 7));
    if (k < N) return 12'(LO + k);
    if (k < 2 * N) return 12'(HI + k - N);
    if (k == 6) return INH;
    return 12'($urandom);
  endfunction

  initial begin
    rst = 1'b1; en = 0; addr = 0; set_v = 0; clr = 0; inc = 0;
    model_clear();
    @(negedge clk);
    do_reset();
    rd(LO, 32'h0, "rst_lo0");
    rd(INH, 32'h0, "rst_inh");

    repeat (5) cycle(1'b0, 12'h0, 0, 0, 3'b001);
    rd(LO, 32'd5, "inc5_lo0");

    cycle(1'b1, LO, 32'hFFFF_FFFF, 32'h0, '0);
    cycle(1'b1, HI, 32'h0, 32'hFFFF_FFFF, '0);
    cycle(1'b0, 12'h0, 0, 0, 3'b001);
    rd(LO, 32'h0, "carry_lo0");
    rd(HI, 32'h1, "carry_hi0");

    cycle(1'b1, LO + 12'd1, 32'hFFFF_FFFF, 32'h0, '0);
    cycle(1'b1, HI + 12'd1, 32'hFFFF_FFFF, 32'h0, '0);
    cycle(1'b0, 12'h0, 0, 0, 3'b010);
    rd(LO + 12'd1, 32'h0, "wrap_lo1");
    chk("wrap_ovf_on", 32'(last_ovf), 32'h2);
    rd(HI + 12'd1, 32'h0, "wrap_hi1");
    chk("wrap_ovf_off", 32'(last_ovf), 32'h0);

    cycle(1'b1, LO + 12'd2, 32'h10, 32'hFFFF_FFFF, 3'b111);
    rd(LO + 12'd2, 32'h10, "wr_wins_lo2");
    rd(LO + 12'd1, 32'h1, "wr_other_lo1");

    cycle(1'b1, INH, 32'h1, 32'h0, '0);
    repeat (4) cycle(1'b0, 12'h0, 0, 0, 3'b111);
    rd(LO, 32'h1, "inh_lo0");
    rd(LO + 12'd1, 32'h5, "inh_lo1");
    rd(LO + 12'd2, 32'h14, "inh_lo2");
    rd(INH, 32'h1, "inh_rd");
    cycle(1'b1, 12'h123, 32'hFFFF_FFFF, 32'h0, '0);
    chk("unmap_ack", 32'(last_ack), 32'h0);
    chk("unmap_read", last_rd, 32'h0);
    cycle(1'b1, INH, 32'h0, 32'hFFFF_FFFF, '0);

    cycle(1'b1, HI, 32'h0, 32'hFFFF_FFFF, '0);
    cycle(1'b1, LO, 32'hFFFF_FFFF, 32'h0, '0);
    rd(LO, 32'hFFFF_FFFF, "snap_lo0");
    cycle(1'b0, 12'h0, 0, 0, 3'b001);
`ifdef CSR_COUNTER_HI_SNAPSHOT_EN
    rd(HI, 32'h0, "snap_hi0");
`else
    rd(HI, 32'h1, "snap_hi0");
`endif

    for (int t = 0; t < 1500; t++) begin
      logic [31:0] s;
      logic [31:0] c;
      s = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
      c = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
      cycle(1'($urandom_range(0, 2) != 0), rand_addr(), s, c,
            N'($urandom));
      if (t == 700) begin
        do_reset();
        rd(LO + 12'd1, 32'h0, "rst_mid_lo1");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
